dr32e_branch_resolve: RTL and testbench
=======================================

// Module: dr32e_branch_resolve
// PURPOSE
//  Consumer end of the fetch-stage static branch prediction. Queues every prediction issued by
//  fetch (taken/not-taken + target), checks each against the in-order outcome resolved in
//  execute, and on mismatch issues a one-cycle redirect with the correct PC and flushes the queue.
//  Also keeps branch/mispredict statistics counters.
// PARAMETERS
//  DEPTH        4    prediction queue entries; power of two, >= 2
//  CNT_W        32   width of statistics counters
// PORTS
//  clk_i              in   1      clock, all state on rising edge
//  rst_i              in   1      synchronous reset, active-high
//  pred_valid_i       in   1      fetch presents a control-transfer instruction (CTI) prediction
//  pred_ready_o       out  1      queue can accept pred_* this cycle
//  pred_pc_i          in   32     PC of the predicted instruction
//  pred_compressed_i  in   1      instruction is 16-bit (fall-through = pc+2, else pc+4)
//  pred_taken_i       in   1      predicted taken
//  pred_target_i      in   32     predicted target (meaningful when pred_taken_i)
//  res_valid_i        in   1      execute resolves the oldest queued CTI this cycle
//  res_taken_i        in   1      actual direction
//  res_target_i       in   32     actual target (meaningful when res_taken_i)
//  redirect_o         out  1      one-cycle pulse: fetch must restart at redirect_pc_o
//  redirect_pc_o      out  32     correct next PC
//  resolve_err_o      out  1      one-cycle pulse: res_valid_i with empty queue or during REDIRECT
//  stat_cti_o         out  CNT_W  count of resolved CTIs, saturating
//  stat_mispred_o     out  CNT_W  count of mispredictions, saturating
// BEHAVIOUR
//  Reset: queue empty, state RUN, redirect_o=0, redirect_pc_o=0, resolve_err_o=0, counters=0,
//   pred_ready_o=1 from first cycle after reset. Reset mid-operation discards queue and pending redirect.
//  Push: entry written when pred_valid_i & pred_ready_o. pred_ready_o = (state==RUN) & ~full.
//   Full and simultaneous valid resolve: push still refused (ready not based on pop).
//  Resolve: when res_valid_i & ~empty & state==RUN, compare against head entry and pop it.
//   mispredict = (res_taken_i != head.taken) | (res_taken_i & (res_target_i != head.target)).
//   correct PC = res_taken_i ? res_target_i : head.pc + (head.compressed ? 2 : 4), 32-bit wrap.
//  Latency: resolve in cycle N -> redirect_o=1, redirect_pc_o valid in cycle N+1, for 1 cycle.
//   redirect_pc_o holds last value when redirect_o=0.
//  FSM: RUN -> REDIRECT on mispredict; REDIRECT -> RUN unconditionally after 1 cycle.
//   On mispredict the whole queue is cleared at the same edge, including a push accepted in
//   cycle N (wrong-path). In REDIRECT: pred_ready_o=0, res_valid_i ignored and flagged.
//  Correct prediction: pop only, no redirect; simultaneous push+pop keeps occupancy constant.
//  Error: res_valid_i with empty queue or in REDIRECT -> resolve_err_o=1 in N+1, no state change.
//  Counters: stat_cti_o +1 per accepted resolve; stat_mispred_o +1 per mispredict;
//   both saturate at all-ones, never wrap.
//  Pointers: log2(DEPTH)+1 bits, wrap-around natural; full = MSB differ & rest equal.
// STRUCTURE
//  dr32e_pkg: bp_entry_t {pc[31:0], target[31:0], taken, compressed}; br_res_state_e {RUN, REDIRECT}.
//  Sub-module dr32e_pred_fifo: synchronous DEPTH-entry FIFO of bp_entry_t with push/pop/clear,
//   full/empty, head output (first-word fall-through). Top holds compare, FSM, counters.
// TESTING
//  1 Push {pc=0x100,taken=1,tgt=0x0F0}; resolve taken,0x0F0 -> no redirect, stat_cti=1, mispred=0.
//  2 Push {pc=0x200,taken=0,compressed=1}; resolve taken,0x300 -> N+1 redirect=1, pc=0x300;
//    then push {pc=0x204,taken=0,compressed=0}, resolve not-taken -> no redirect;
//    push {pc=0x208,taken=1,tgt=0x180}, resolve not-taken -> redirect pc=0x20C.
//  3 Fill DEPTH=4 entries -> pred_ready_o=0; resolve+push same cycle -> push refused, occupancy 3.
//  4 Queue 3 entries, head mispredicts with push in same cycle -> queue empty after edge,
//    pred_ready_o=0 for 1 cycle, next resolve -> resolve_err_o=1.
//  5 Resolve with empty queue after reset -> resolve_err_o pulse, counters stay 0.
//  6 Assert rst_i during REDIRECT with 2 queued -> next cycle redirect_o=0, empty, counters 0;
//    pc=0xFFFFFFFE compressed not-taken mispredicted taken -> redirect_pc_o=0x00000000.

Source files
------------

// File: rtl/dr32e_pkg.sv
// Shared types for the dr32e branch-resolve slice: prediction queue entry,
// resolve FSM states and the fall-through PC helper.
package dr32e_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        compressed;
  } bp_entry_t;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } br_res_state_e;

  // Next sequential PC after a CTI; wraps naturally at 32 bits.
  function automatic logic [31:0] fall_through(input logic [31:0] pc,
                                               input logic        compressed);
    return pc + (compressed ? 32'd2 : 32'd4);
  endfunction

endpackage

// File: rtl/dr32e_branch_resolve_if.sv
// Fetch/execute/stat signal bundle between the branch-resolve block and its
// surroundings. slave = resolve block side, master = environment side.
interface dr32e_branch_resolve_if #(
  parameter int unsigned CNT_W = 32
);
  logic             pred_valid_i;
  logic             pred_ready_o;
  logic [31:0]      pred_pc_i;
  logic             pred_compressed_i;
  logic             pred_taken_i;
  logic [31:0]      pred_target_i;
  logic             res_valid_i;
  logic             res_taken_i;
  logic [31:0]      res_target_i;
  logic             redirect_o;
  logic [31:0]      redirect_pc_o;
  logic             resolve_err_o;
  logic [CNT_W-1:0] stat_cti_o;
  logic [CNT_W-1:0] stat_mispred_o;

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_compressed_i, pred_taken_i, pred_target_i,
    input  res_valid_i, res_taken_i, res_target_i,
    output pred_ready_o, redirect_o, redirect_pc_o, resolve_err_o,
    output stat_cti_o, stat_mispred_o
  );

  modport master (
    output pred_valid_i, pred_pc_i, pred_compressed_i, pred_taken_i, pred_target_i,
    output res_valid_i, res_taken_i, res_target_i,
    input  pred_ready_o, redirect_o, redirect_pc_o, resolve_err_o,
    input  stat_cti_o, stat_mispred_o
  );
endinterface

// File: rtl/dr32e_pred_fifo.sv
// Prediction queue: DEPTH-entry synchronous FIFO of bp_entry_t with
// first-word fall-through head, and a clear that overrides push/pop.
module dr32e_pred_fifo
  import dr32e_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  bp_entry_t entry_i,
  input  logic      pop_i,
  input  logic      clear_i,
  output logic      full_o,
  output logic      empty_o,
  output bp_entry_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  bp_entry_t   mem_q [DEPTH];
  bp_entry_t   mem_d [DEPTH];

  // Next pointers and storage; clear discards everything incl. a same-cycle push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q[AW-1:0]] = entry_i;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care while the pointers mark them empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/dr32e_branch_resolve.sv
// Branch resolve: queues fetch predictions, checks them in order against
// execute outcomes, redirects fetch on mispredict and keeps statistics.
module dr32e_branch_resolve
  import dr32e_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dr32e_branch_resolve_if.slave  bus
);

  br_res_state_e    state_q, state_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             resolve_err_q, resolve_err_d;
  logic [CNT_W-1:0] cti_q, cti_d;
  logic [CNT_W-1:0] mispred_q, mispred_d;

  logic      fifo_full, fifo_empty;
  bp_entry_t head, new_entry;
  logic      push, res_accept, mispredict;
  logic [31:0] correct_pc;

  assign bus.pred_ready_o = (state_q == RUN) && !fifo_full;
  assign push             = bus.pred_valid_i && bus.pred_ready_o;
  assign res_accept       = bus.res_valid_i && !fifo_empty && (state_q == RUN);

  assign new_entry.pc         = bus.pred_pc_i;
  assign new_entry.target     = bus.pred_target_i;
  assign new_entry.taken      = bus.pred_taken_i;
  assign new_entry.compressed = bus.pred_compressed_i;

  dr32e_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (res_accept),
    .clear_i (mispredict),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // Compare the head prediction against the resolved outcome.
  always_comb begin
    mispredict = 1'b0;
    correct_pc = bus.res_taken_i ? bus.res_target_i
                                 : fall_through(head.pc, head.compressed);
    if (res_accept) begin
      mispredict = (bus.res_taken_i != head.taken) ||
                   (bus.res_taken_i && (bus.res_target_i != head.target));
    end
  end

  // Next-state for FSM, redirect/error pulses and saturating counters.
  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    resolve_err_d = bus.res_valid_i && !res_accept;
    cti_d         = cti_q;
    mispred_d     = mispred_q;
    case (state_q)
      RUN:      if (mispredict) state_d = REDIRECT;
      REDIRECT: state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (mispredict) begin
      redirect_d    = 1'b1;
      redirect_pc_d = correct_pc;
    end
    if (res_accept && (cti_q != '1)) begin
      cti_d = cti_q + 1'b1;
    end
    if (mispredict && (mispred_q != '1)) begin
      mispred_d = mispred_q + 1'b1;
    end
  end

  // Registered state and outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      resolve_err_q <= 1'b0;
      cti_q         <= '0;
      mispred_q     <= '0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      resolve_err_q <= resolve_err_d;
      cti_q         <= cti_d;
      mispred_q     <= mispred_d;
    end
  end

  assign bus.redirect_o     = redirect_q;
  assign bus.redirect_pc_o  = redirect_pc_q;
  assign bus.resolve_err_o  = resolve_err_q;
  assign bus.stat_cti_o     = cti_q;
  assign bus.stat_mispred_o = mispred_q;

endmodule

// File: tb/tb_dr32e_branch_resolve.sv
// Self-checking bench for dr32e_branch_resolve: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_dr32e_branch_resolve;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TB_CNT_W = 4;
  localparam int unsigned SAT      = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dr32e_branch_resolve_if #(.CNT_W(TB_CNT_W)) bus ();

  dr32e_branch_resolve #(.DEPTH(DEPTH), .CNT_W(TB_CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Reference model state.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    bit          tk;
    bit          comp;
  } m_ent_t;

  m_ent_t      mq[$];
  bit          m_in_redir;
  bit          m_redir;
  bit          m_err;
  logic [31:0] m_pc;
  int unsigned m_cti;
  int unsigned m_mis;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !m_in_redir && (mq.size() < DEPTH);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_in_redir = 0;
    m_redir    = 0;
    m_err      = 0;
    m_pc       = '0;
    m_cti      = 0;
    m_mis      = 0;
  endtask

  // One clock edge of the architectural rules.
  task automatic model_edge();
    bit     rdy, push, acc, mis;
    m_ent_t h, n;
    logic [31:0] good;
    rdy  = model_ready();
    push = bus.pred_valid_i && rdy;
    acc  = bus.res_valid_i && (mq.size() > 0) && !m_in_redir;
    mis  = 0;
    n.pc = bus.pred_pc_i; n.tgt = bus.pred_target_i;
    n.tk = bus.pred_taken_i; n.comp = bus.pred_compressed_i;
    m_err   = bus.res_valid_i && !acc;
    m_redir = 0;
    if (acc) begin
      h = mq.pop_front();
      mis = (bus.res_taken_i != h.tk) || (bus.res_taken_i && bus.res_target_i != h.tgt);
      if (m_cti < SAT) m_cti++;
      if (mis) begin
        if (m_mis < SAT) m_mis++;
        good = bus.res_taken_i ? bus.res_target_i : h.pc + (h.comp ? 32'd2 : 32'd4);
        m_pc = good;
        m_redir = 1;
        mq.delete();
      end
    end
    if (push && !mis) mq.push_back(n);
    m_in_redir = mis;
  endtask

  task automatic step(input bit in_reset);
    if (!in_reset) check("pred_ready", {31'd0, bus.pred_ready_o}, {31'd0, model_ready()});
    @(posedge clk);
    if (in_reset) model_reset(); else model_edge();
    #1;
    check("redirect", {31'd0, bus.redirect_o}, {31'd0, m_redir});
    check("redirect_pc", bus.redirect_pc_o, m_pc);
    check("resolve_err", {31'd0, bus.resolve_err_o}, {31'd0, m_err});
    check("stat_cti", {28'd0, bus.stat_cti_o}, m_cti);
    check("stat_mispred", {28'd0, bus.stat_mispred_o}, m_mis);
  endtask

  task automatic idle_inputs();
    bus.pred_valid_i = 0; bus.pred_pc_i = '0; bus.pred_compressed_i = 0;
    bus.pred_taken_i = 0; bus.pred_target_i = '0;
    bus.res_valid_i = 0; bus.res_taken_i = 0; bus.res_target_i = '0;
  endtask

  // Apply one cycle of stimulus then return inputs to idle.
  task automatic drive(input bit pv, input logic [31:0] pc, input bit comp, input bit tk,
                       input logic [31:0] tgt, input bit rv, input bit rtk,
                       input logic [31:0] rtgt);
    bus.pred_valid_i = pv; bus.pred_pc_i = pc; bus.pred_compressed_i = comp;
    bus.pred_taken_i = tk; bus.pred_target_i = tgt;
    bus.res_valid_i = rv; bus.res_taken_i = rtk; bus.res_target_i = rtgt;
    step(0);
    idle_inputs();
  endtask

  task automatic push_only(input logic [31:0] pc, input bit comp, input bit tk, input logic [31:0] tgt);
    drive(1, pc, comp, tk, tgt, 0, 0, '0);
  endtask

  task automatic resolve_only(input bit rtk, input logic [31:0] rtgt);
    drive(0, '0, 0, 0, '0, 1, rtk, rtgt);
  endtask

  task automatic do_reset();
    rst = 1;
    step(1);
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    do_reset();
    check("reset_ready", {31'd0, bus.pred_ready_o}, 32'd1);

    // 1: correct taken prediction
    push_only(32'h100, 0, 1, 32'h0F0);
    resolve_only(1, 32'h0F0);
    check("t1_redirect", {31'd0, bus.redirect_o}, 32'd0);
    check("t1_cti", {28'd0, bus.stat_cti_o}, 32'd1);

    // 2: mispredicts with taken and with fall-through correction
    push_only(32'h200, 1, 0, '0);
    resolve_only(1, 32'h300);
    check("t2_redir", {31'd0, bus.redirect_o}, 32'd1);
    check("t2_redir_pc", bus.redirect_pc_o, 32'h300);
    drive(0, '0, 0, 0, '0, 0, 0, '0);
    push_only(32'h204, 0, 0, '0);
    resolve_only(0, '0);
    check("t2_no_redir", {31'd0, bus.redirect_o}, 32'd0);
    push_only(32'h208, 0, 1, 32'h180);
    resolve_only(0, '0);
    check("t2_ft_pc", bus.redirect_pc_o, 32'h20C);
    drive(0, '0, 0, 0, '0, 0, 0, '0);

    // 3: full queue refuses a push even with a same-cycle pop
    for (int unsigned i = 0; i < DEPTH; i++) push_only(32'h400 + 8 * i, 0, 0, '0);
    check("t3_full_ready", {31'd0, bus.pred_ready_o}, 32'd0);
    drive(1, 32'h500, 0, 0, '0, 1, 0, '0);
    check("t3_ready_after", {31'd0, bus.pred_ready_o}, 32'd1);
    check("t3_occupancy", mq.size(), 32'd3);
    for (int unsigned i = 0; i < 3; i++) resolve_only(0, '0);

    // 4: mispredict flushes queue including same-cycle push
    for (int unsigned i = 0; i < 3; i++) push_only(32'h500 + 4 * i, 0, 0, '0);
    drive(1, 32'h700, 0, 0, '0, 1, 1, 32'h600);
    check("t4_redir_pc", bus.redirect_pc_o, 32'h600);
    check("t4_ready_low", {31'd0, bus.pred_ready_o}, 32'd0);
    drive(0, '0, 0, 0, '0, 0, 0, '0);
    resolve_only(0, '0);
    check("t4_err", {31'd0, bus.resolve_err_o}, 32'd1);

    // 5: resolve on empty queue right after reset
    do_reset();
    resolve_only(1, 32'h40);
    check("t5_err", {31'd0, bus.resolve_err_o}, 32'd1);
    check("t5_cti", {28'd0, bus.stat_cti_o}, 32'd0);

    // 6: reset during REDIRECT, then PC wrap on fall-through
    push_only(32'h800, 0, 0, '0);
    push_only(32'h804, 0, 0, '0);
    resolve_only(1, 32'h900);
    do_reset();
    check("t6_redir_clr", {31'd0, bus.redirect_o}, 32'd0);
    check("t6_ready", {31'd0, bus.pred_ready_o}, 32'd1);
    push_only(32'hFFFF_FFFE, 1, 1, 32'h50);
    resolve_only(0, '0);
    check("t6_wrap_pc", bus.redirect_pc_o, 32'h0000_0000);

    // Random traffic; counters are narrow so saturation is reached.
    for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
      logic [31:0] pc;
      bit rtk;
      logic [31:0] rtgt;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | ($urandom & 32'h6)) : ($urandom & 32'hFFFF_FFFE);
      rtk  = $urandom_range(0, 1);
      rtgt = $urandom & 32'hFFFF_FFFE;
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
        rtk = mq[0].tk;
        if ($urandom_range(0, 3) != 0) rtgt = mq[0].tgt;
      end
      drive($urandom_range(0, 1), pc, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom & 32'hFFFF_FFFE, $urandom_range(0, 2) != 0, rtk, rtgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
